param_data_connection_block: RTL and testbench



---
 rtl/param_data_connection_block_if.sv | 38 +++
 rtl/param_data_connection_block.sv | 103 ++++++++++
 tb/tb_param_data_connection_block.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_data_connection_block_if.sv
`default_nettype none
// ============================================================================
// Module      : param_data_connection_block_if
// Description : Channel, CLB data and serial-configuration bundle for the
//               data connection block.
// Revision    : 1.0 - initial release
// ============================================================================
interface param_data_connection_block_if #(
    parameter int NS_W        = 64,
    parameter int WORD_WIDTH  = 8,
    parameter int DCB_DATAIN  = 4,
    parameter int DCB_DATAOUT = 2
);
    logic                              en;
    logic                              cen;
    logic                              cset;
    logic                              shift_in;
    logic                              shift_out;
    logic                              cset_out;
    logic [NS_W-1:0]                   north_in;
    logic [NS_W-1:0]                   south_in;
    logic [NS_W-1:0]                   north_out;
    logic [NS_W-1:0]                   south_out;
    logic [WORD_WIDTH*DCB_DATAIN-1:0]  data_input;
    logic [WORD_WIDTH*DCB_DATAOUT-1:0] data_output;

    // master is the surrounding fabric, slave is the connection block
    modport master (
        output en, cen, cset, shift_in, north_in, south_in, data_output,
        input  shift_out, cset_out, north_out, south_out, data_input
    );

    modport slave (
        input  en, cen, cset, shift_in, north_in, south_in, data_output,
        output shift_out, cset_out, north_out, south_out, data_input
    );
endinterface
`default_nettype wire

// File: rtl/param_data_connection_block.sv
`default_nettype none
// ============================================================================
// Module      : param_data_connection_block
// Description : Routes N/S channel track groups to CLB data words and back,
//               configured through a serially loaded, atomically committed
//               shadow chain.
// Revision    : 1.0 - initial release
// ============================================================================
module param_data_connection_block #(
    parameter int NS_W        = 64,
    parameter int WORD_WIDTH  = 8,
    parameter int DCB_DATAIN  = 4,
    parameter int DCB_DATAOUT = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    param_data_connection_block_if.slave bus
);
    localparam int G     = NS_W / WORD_WIDTH;
    localparam int SI    = $clog2(2 * G);
    localparam int SO    = $clog2(DCB_DATAOUT + 1);
    localparam int CFG_W = DCB_DATAIN * (SI + 1) + G * SO;

    logic [CFG_W-1:0]                 r_shadow;
    logic [CFG_W-1:0]                 r_active;
    logic                             r_cset_out;
    logic [WORD_WIDTH*DCB_DATAIN-1:0] r_data_in;
    logic [WORD_WIDTH*DCB_DATAIN-1:0] w_mux;

    // Commit samples the pre-shift shadow, so a same-cycle shift is not seen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow   <= '0;
            r_active   <= '0;
            r_cset_out <= 1'b0;
            r_data_in  <= '0;
        end else begin
            if (bus.cen) begin
                r_shadow <= {r_shadow[CFG_W-2:0], bus.shift_in};
            end
            if (bus.cset) begin
                r_active <= r_shadow;
            end
            r_cset_out <= bus.cset;
            if (bus.en) begin
                r_data_in <= w_mux;
            end
        end
    end

    assign bus.shift_out = r_shadow[CFG_W-1];
    assign bus.cset_out  = r_cset_out;

    for (genvar i = 0; i < DCB_DATAIN; i++) begin : g_in
        logic [SI-1:0]         w_sel;
        logic                  w_reg;
        logic [WORD_WIDTH-1:0] w_word;

        assign w_sel = r_active[i*(SI+1) +: SI];
        assign w_reg = r_active[i*(SI+1) + SI];

        // Unmatched select codes fall through to zero
        always_comb begin
            w_word = '0;
            for (int g = 0; g < G; g++) begin
                if (w_sel == SI'(g)) begin
                    w_word = bus.north_in[g*WORD_WIDTH +: WORD_WIDTH];
                end
                if (w_sel == SI'(g + G)) begin
                    w_word = bus.south_in[g*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end

        assign w_mux[i*WORD_WIDTH +: WORD_WIDTH] = w_word;
        assign bus.data_input[i*WORD_WIDTH +: WORD_WIDTH] =
            w_reg ? r_data_in[i*WORD_WIDTH +: WORD_WIDTH] : w_word;
    end

    for (genvar g = 0; g < G; g++) begin : g_grp
        logic [SO-1:0]         w_src;
        logic [WORD_WIDTH-1:0] w_north;
        logic [WORD_WIDTH-1:0] w_south;

        assign w_src = r_active[DCB_DATAIN*(SI+1) + g*SO +: SO];

        // Source codes beyond the data_output count keep the feedthrough
        always_comb begin
            w_north = bus.south_in[g*WORD_WIDTH +: WORD_WIDTH];
            w_south = bus.north_in[g*WORD_WIDTH +: WORD_WIDTH];
            for (int k = 0; k < DCB_DATAOUT; k++) begin
                if (w_src == SO'(k + 1)) begin
                    w_north = bus.data_output[k*WORD_WIDTH +: WORD_WIDTH];
                    w_south = bus.data_output[k*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end

        assign bus.north_out[g*WORD_WIDTH +: WORD_WIDTH] = w_north;
        assign bus.south_out[g*WORD_WIDTH +: WORD_WIDTH] = w_south;
    end
endmodule
`default_nettype wire

// File: tb/tb_param_data_connection_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_data_connection_block
// Description : Self-checking bench with reference model for the data
//               connection block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_data_connection_block;
    localparam int NS_W  = 64;
    localparam int WW    = 8;
    localparam int NI    = 4;
    localparam int NO    = 2;
    localparam int G     = 8;
    localparam int SI    = 4;
    localparam int SO    = 2;
    localparam int CFG_W = 36;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_data_connection_block_if #(
        .NS_W(NS_W), .WORD_WIDTH(WW), .DCB_DATAIN(NI), .DCB_DATAOUT(NO)
    ) bus ();

    param_data_connection_block #(
        .NS_W(NS_W), .WORD_WIDTH(WW), .DCB_DATAIN(NI), .DCB_DATAOUT(NO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [CFG_W-1:0] m_shadow = '0;
    logic [CFG_W-1:0] m_active = '0;
    logic [WW-1:0]    m_reg [NI];
    logic             m_cso = 1'b0;
    int               n_vec = 0;
    int               n_bad = 0;

    typedef struct {
        int          sel;
        logic [WW-1:0] exp;
    } vec_t;
    vec_t tbl [6];

    function automatic int field(input logic [CFG_W-1:0] c, input int lsb, input int w);
        logic [CFG_W-1:0] f;
        f = c >> lsb;
        return int'(f % (CFG_W'(1) << w));
    endfunction

    function automatic logic [WW-1:0] pick(input logic [NS_W-1:0] v, input int g);
        logic [NS_W-1:0] s;
        s = v >> (g * WW);
        return s[WW-1:0];
    endfunction

    function automatic logic [WW-1:0] mux_word(input logic [CFG_W-1:0] c, input int i);
        int sel;
        sel = field(c, i * (SI + 1), SI);
        if (sel < G)     return pick(bus.north_in, sel);
        if (sel < 2 * G) return pick(bus.south_in, sel - G);
        return '0;
    endfunction

    function automatic logic [NI*WW-1:0] exp_data();
        logic [NI*WW-1:0] r;
        r = '0;
        for (int i = 0; i < NI; i++) begin
            if (field(m_active, i * (SI + 1) + SI, 1) == 1)
                r[i*WW +: WW] = m_reg[i];
            else
                r[i*WW +: WW] = mux_word(m_active, i);
        end
        return r;
    endfunction

    task automatic exp_routes(output logic [NS_W-1:0] n, output logic [NS_W-1:0] s);
        int src;
        for (int g = 0; g < G; g++) begin
            src = field(m_active, NI * (SI + 1) + g * SO, SO);
            if (src >= 1 && src <= NO) begin
                n[g*WW +: WW] = pick({48'd0, bus.data_output}, src - 1);
                s[g*WW +: WW] = pick({48'd0, bus.data_output}, src - 1);
            end else begin
                n[g*WW +: WW] = pick(bus.south_in, g);
                s[g*WW +: WW] = pick(bus.north_in, g);
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NS_W-1:0] en_, es_;
        #1;
        exp_routes(en_, es_);
        chk({tag, ".shift_out"},  64'(bus.shift_out),  64'(m_shadow[CFG_W-1]));
        chk({tag, ".cset_out"},   64'(bus.cset_out),   64'(m_cso));
        chk({tag, ".north_out"},  bus.north_out,       en_);
        chk({tag, ".south_out"},  bus.south_out,       es_);
        chk({tag, ".data_input"}, 64'(bus.data_input), 64'(exp_data()));
    endtask

    task automatic step();
        logic [CFG_W-1:0] ns, na;
        logic [WW-1:0]    nr [NI];
        logic             nc;
        ns = m_shadow;
        na = m_active;
        nr = m_reg;
        if (rst) begin
            ns = '0;
            na = '0;
            nc = 1'b0;
            for (int i = 0; i < NI; i++) nr[i] = '0;
        end else begin
            if (bus.cset) na = m_shadow;
            if (bus.cen)  ns = {m_shadow[CFG_W-2:0], bus.shift_in};
            nc = bus.cset;
            if (bus.en) for (int i = 0; i < NI; i++) nr[i] = mux_word(m_active, i);
        end
        @(posedge clk);
        #1;
        m_shadow = ns;
        m_active = na;
        m_reg    = nr;
        m_cso    = nc;
    endtask

    function automatic logic [CFG_W-1:0] cfg_in(input logic [CFG_W-1:0] c, input int i,
                                                input int sel, input bit rm);
        logic [CFG_W-1:0] v;
        v = CFG_W'(sel % (1 << SI)) | (CFG_W'(rm) << SI);
        c = c & ~(CFG_W'((1 << (SI + 1)) - 1) << (i * (SI + 1)));
        return c | (v << (i * (SI + 1)));
    endfunction

    function automatic logic [CFG_W-1:0] cfg_grp(input logic [CFG_W-1:0] c, input int g, input int src);
        int lsb;
        lsb = NI * (SI + 1) + g * SO;
        c = c & ~(CFG_W'((1 << SO) - 1) << lsb);
        return c | (CFG_W'(src % (1 << SO)) << lsb);
    endfunction

    task automatic load_cfg(input logic [CFG_W-1:0] c);
        bus.cen = 1'b1;
        for (int k = CFG_W - 1; k >= 0; k--) begin
            bus.shift_in = c[k];
            step();
        end
        bus.cen = 1'b0;
        bus.shift_in = 1'b0;
    endtask

    task automatic commit();
        bus.cset = 1'b1;
        step();
        bus.cset = 1'b0;
    endtask

    task automatic rand_data();
        bus.north_in    = {$urandom, $urandom};
        bus.south_in    = {$urandom, $urandom};
        bus.data_output = 16'($urandom);
    endtask

    initial begin
        logic [CFG_W-1:0] cfg, x;
        logic [CFG_W-1:0] pat;

        for (int i = 0; i < NI; i++) m_reg[i] = '0;
        tbl[0] = '{0,  8'h10};
        tbl[1] = '{3,  8'h13};
        tbl[2] = '{7,  8'h17};
        tbl[3] = '{8,  8'h80};
        tbl[4] = '{9,  8'h81};
        tbl[5] = '{15, 8'h87};

        // Reset with config controls active
        rst = 1'b1;
        bus.en = 1'b1; bus.cen = 1'b1; bus.cset = 1'b1; bus.shift_in = 1'b1;
        rand_data();
        step();
        step();
        rst = 1'b0; bus.en = 1'b0; bus.cen = 1'b0; bus.cset = 1'b0; bus.shift_in = 1'b0;
        check_all("reset");
        chk("reset.north_fb", bus.north_out, bus.south_in);
        chk("reset.south_fb", bus.south_out, bus.north_in);
        chk("reset.words", 64'(bus.data_input), 64'({4{bus.north_in[7:0]}}));
        chk("reset.shift_out", 64'(bus.shift_out), 64'd0);

        // Shift integrity
        pat = 36'hA5F0C3E1B;
        bus.cen = 1'b1;
        for (int k = CFG_W - 1; k >= 0; k--) begin
            bus.shift_in = pat[k];
            step();
            check_all("shift_load");
        end
        for (int j = 0; j < CFG_W; j++) begin
            #1;
            chk("shift_out_bit", 64'(bus.shift_out), 64'(pat[CFG_W-1-j]));
            bus.shift_in = 1'b0;
            step();
        end
        bus.cen = 1'b0;
        check_all("shift_done");
        chk("shift.routing_unchanged", bus.north_out, bus.south_in);

        // Commit: input0 from south group 1, group 3 driven by data_output word 1
        rand_data();
        cfg = cfg_grp(cfg_in('0, 0, 9, 1'b0), 3, 2);
        load_cfg(cfg);
        commit();
        check_all("commit");
        chk("commit.word0", 64'(bus.data_input[7:0]), 64'(bus.south_in[15:8]));
        chk("commit.north3", 64'(bus.north_out[31:24]), 64'(bus.data_output[15:8]));
        chk("commit.south3", 64'(bus.south_out[31:24]), 64'(bus.data_output[15:8]));
        chk("commit.cset_out", 64'(bus.cset_out), 64'd1);
        step();
        chk("commit.cset_out_low", 64'(bus.cset_out), 64'd0);

        // Registered mode capture and hold
        cfg = cfg_in(cfg, 1, 2, 1'b1);
        load_cfg(cfg);
        commit();
        bus.north_in[23:16] = 8'h11;
        bus.en = 1'b1;
        step();
        bus.en = 1'b0;
        bus.north_in[23:16] = 8'h22;
        step();
        step();
        check_all("reg_hold");
        chk("reg.hold", 64'(bus.data_input[15:8]), 64'h11);
        bus.en = 1'b1;
        #1;
        chk("reg.no_comb", 64'(bus.data_input[15:8]), 64'h11);
        step();
        bus.en = 1'b0;
        check_all("reg_update");
        chk("reg.update", 64'(bus.data_input[15:8]), 64'h22);

        // Table-driven input select decode
        bus.north_in = 64'h17161514_13121110;
        bus.south_in = 64'h87868584_83828180;
        foreach (tbl[t]) begin
            load_cfg(cfg_in('0, 0, tbl[t].sel, 1'b0));
            commit();
            check_all("table");
            chk("table.word0", 64'(bus.data_input[7:0]), 64'(tbl[t].exp));
        end

        // Simultaneous shift and commit; group0 source code out of range
        rand_data();
        x = cfg_grp(cfg_grp(cfg_in(cfg_in('0, 0, 12, 1'b0), 2, 5, 1'b0), 0, 3), 1, 1);
        load_cfg(x);
        bus.cen = 1'b1; bus.cset = 1'b1; bus.shift_in = 1'b1;
        step();
        bus.cen = 1'b0; bus.cset = 1'b0; bus.shift_in = 1'b0;
        check_all("cen_cset");
        chk("cc.grp0_south_fb", 64'(bus.south_out[7:0]), 64'(bus.north_in[7:0]));
        chk("cc.grp0_north_fb", 64'(bus.north_out[7:0]), 64'(bus.south_in[7:0]));
        chk("cc.word0", 64'(bus.data_input[7:0]), 64'(bus.south_in[39:32]));
        chk("cc.grp1", 64'(bus.north_out[15:8]), 64'(bus.data_output[7:0]));

        // Reset mid-shift discards the partial pattern
        bus.cen = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.shift_in = 1'($urandom);
            step();
        end
        bus.cen = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        commit();
        check_all("rst_mid");
        chk("rst_mid.north", bus.north_out, bus.south_in);
        chk("rst_mid.south", bus.south_out, bus.north_in);
        chk("rst_mid.words", 64'(bus.data_input), 64'({4{bus.north_in[7:0]}}));

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rand_data();
            bus.cen      = 1'($urandom);
            bus.cset     = ($urandom_range(0, 7) == 0);
            bus.shift_in = 1'($urandom);
            bus.en       = 1'($urandom);
            rst          = ($urandom_range(0, 99) == 0);
            check_all("random");
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
